fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS core. Owns the program counter and drives it to the instruction memory, which returns the 32-bit big-endian instruction word combinationally. Registers that word into the IF/ID pipeline register for the decode stage. Handles sequential fetch, branch/jump redirects, hazard stalls, flushes and out-of-range fetch detection.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/pc_unit.sv | 47 ++++
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: instruction constants, the IF/ID
// bundle and the fetch-address legality helper.
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [31:0]        pc_plus4;
    logic               valid;
  } if_id_t;

  // Whole word must lie inside memory; computed in 33 bits so PC near 2^32 cannot wrap.
  function automatic logic pc_is_legal(input logic [31:0] pc, input int unsigned imem_bytes);
    logic [32:0] last_byte;
    last_byte = {1'b0, pc} + 33'd3;
    return (pc[1:0] == 2'b00) && (last_byte < 33'(imem_bytes));
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC selection (redirect > stall >
// illegal hold > sequential) and combinational legality of the current PC.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        pc_legal_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_STEP;
  assign pc_legal_o = pc_is_legal(pc_q, IMEM_BYTES);

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_target_i & 32'hFFFF_FFFC;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (!pc_legal_o) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives PC to instruction memory, registers the
// returned word into IF/ID and pulses Fetch_Fault when PC turns illegal.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 52
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        PC,
  input  logic [INSTR_W-1:0] Instruction_Code,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [31:0]        Redirect_Target,
  output logic [INSTR_W-1:0] IF_ID_Instruction,
  output logic [31:0]        IF_ID_PC_Plus4,
  output logic               IF_ID_Valid,
  output logic               Fetch_Fault
);

  logic [31:0] pc_plus4_s;
  logic        pc_legal_s;

  if_id_t if_id_q, if_id_d;
  logic   prev_legal_q, prev_legal_d;
  logic   fault_q, fault_d;

  pc_unit #(
    .PC_RESET   (PC_RESET),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_unit (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (Stall),
    .redirect_i        (Redirect),
    .redirect_target_i (Redirect_Target),
    .pc_o              (PC),
    .pc_plus4_o        (pc_plus4_s),
    .pc_legal_o        (pc_legal_s)
  );

  always_comb begin
    if_id_d = if_id_q;
    if (Redirect) begin
      if_id_d = '{instruction: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
    end else if (Stall) begin
      if_id_d = if_id_q;
    end else if (!pc_legal_s) begin
      if_id_d = '{instruction: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
    end else begin
      if_id_d = '{instruction: Instruction_Code, pc_plus4: pc_plus4_s, valid: 1'b1};
    end
  end

  // Reset counts as "previously legal", so an illegal PC_RESET still faults once.
  always_comb begin
    prev_legal_d = pc_legal_s;
    fault_d      = prev_legal_q && !pc_legal_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q      <= '{instruction: NOP_INSTR, pc_plus4: 32'd0, valid: 1'b0};
      prev_legal_q <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      if_id_q      <= if_id_d;
      prev_legal_q <= prev_legal_d;
      fault_q      <= fault_d;
    end
  end

  assign IF_ID_Instruction = if_id_q.instruction;
  assign IF_ID_PC_Plus4    = if_id_q.pc_plus4;
  assign IF_ID_Valid       = if_id_q.valid;
  assign Fetch_Fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage against a 52-byte instruction memory,
// plus hand-written asynchronous-reset sequences.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_s;
  logic [31:0] instr_code_s;
  logic        stall_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] ifid_instr_s;
  logic [31:0] ifid_pc4_s;
  logic        ifid_valid_s;
  logic        fault_s;

  logic [31:0] mem [0:15];
  int total;
  int bad;

  fetch_stage #(
    .PC_RESET   (32'h0000_0000),
    .IMEM_BYTES (52)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .PC                (pc_s),
    .Instruction_Code  (instr_code_s),
    .Stall             (stall_s),
    .Redirect          (redirect_s),
    .Redirect_Target   (target_s),
    .IF_ID_Instruction (ifid_instr_s),
    .IF_ID_PC_Plus4    (ifid_pc4_s),
    .IF_ID_Valid       (ifid_valid_s),
    .Fetch_Fault       (fault_s)
  );

  assign instr_code_s = (pc_s < 32'd52) ? mem[pc_s[5:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic fault);
    chk({tag, ".pc"},    pc_s, pc);
    chk({tag, ".instr"}, ifid_instr_s, instr);
    chk({tag, ".pc4"},   ifid_pc4_s, pc4);
    chk({tag, ".valid"}, {31'd0, ifid_valid_s}, {31'd0, valid});
    chk({tag, ".fault"}, {31'd0, fault_s}, {31'd0, fault});
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] p4, input logic v, input logic f);
    vec_t x;
    x.stall = s; x.redirect = r; x.target = t; x.pc = pc;
    x.instr = ins; x.pc4 = p4; x.valid = v; x.fault = f;
    return x;
  endfunction

  initial begin
    logic [31:0] nop;
    nop = 32'h0000_0000;
    total = 0;
    bad   = 0;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    for (int i = 2; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);

    // stall, redirect, target | pc, instr, pc4, valid, fault
    vecs.push_back(mk(0, 0, 32'h0,  32'h04, mem[0], 32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h08, mem[1], 32'h08, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,  32'h08, mem[1], 32'h08, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,  32'h08, mem[1], 32'h08, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,  32'h08, mem[1], 32'h08, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h0C, mem[2], 32'h0C, 1, 0));
    vecs.push_back(mk(1, 1, 32'h23, 32'h20, nop,    32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h24, mem[8], 32'h24, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h28, mem[9], 32'h28, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h2C, mem[10], 32'h2C, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h30, mem[11], 32'h30, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h34, mem[12], 32'h34, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h34, nop,    32'h00, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,  32'h34, nop,    32'h00, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0,  32'h34, nop,    32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,  32'h00, nop,    32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h04, mem[0], 32'h04, 1, 0));
    vecs.push_back(mk(0, 1, 32'h40, 32'h40, nop,    32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h40, nop,    32'h00, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,  32'h40, nop,    32'h00, 0, 0));
    vecs.push_back(mk(0, 1, 32'h4,  32'h04, nop,    32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,  32'h08, mem[1], 32'h08, 1, 0));

    reset      = 1'b0;
    stall_s    = 1'b0;
    redirect_s = 1'b0;
    target_s   = 32'h0;
    #12;
    chk_all("reset", 32'h0, nop, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall_s    = vecs[i].stall;
      redirect_s = vecs[i].redirect;
      target_s   = vecs[i].target;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
              vecs[i].valid, vecs[i].fault);
    end

    // Asynchronous reset mid-cycle during a stall: state clears without a clock edge.
    stall_s    = 1'b1;
    redirect_s = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, nop, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 32'h0, nop, 32'h0, 1'b0, 1'b0);
    #2;
    reset   = 1'b1;
    stall_s = 1'b0;
    @(posedge clk);
    #1;
    chk_all("first_after_rst", 32'h04, mem[0], 32'h04, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("second_after_rst", 32'h08, mem[1], 32'h08, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
